// File: rtl/pipelined_mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
package pipelined_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

  // Fetches and loads always move a full word.
  localparam logic [3:0] BYTEEN_WORD = 4'b1111;

endpackage

// File: rtl/mem_arb_starve_counter.sv
// Saturating count of arbitrations lost by instruction fetch; at_limit_o
// tells the arbiter to hand the next grant to fetch.
module mem_arb_starve_counter #(
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int unsigned CntW = (Limit < 1) ? 1 : $clog2(Limit + 1);
  localparam logic [CntW-1:0] LimitVal = CntW'(Limit);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increments stop at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LimitVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LimitVal);

endmodule

// File: rtl/pipelined_mem_arbiter.sv
// Shares one external memory port between instruction fetch and the data
// stage. One transaction is outstanding at a time: IDLE arbitrates and
// captures the request, REQ presents it until granted, WAIT returns the
// response to its owner.
module pipelined_mem_arbiter
  import pipelined_mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  // Instruction fetch
  input  logic             i_if_req,
  input  logic [WIDTH-1:0] i_if_addr,
  input  logic             i_if_flush,
  output logic [WIDTH-1:0] o_if_rdata,
  output logic             o_if_rvalid,
  output logic             o_if_stall,
  // Data access
  input  logic             i_d_req,
  input  logic             i_d_we,
  input  logic [WIDTH-1:0] i_d_addr,
  input  logic [WIDTH-1:0] i_d_wdata,
  input  logic [3:0]       i_d_byteen,
  output logic [WIDTH-1:0] o_d_rdata,
  output logic             o_d_rvalid,
  output logic             o_d_stall,
  // Memory port
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic [3:0]       o_mem_byteen,
  input  logic             i_mem_gnt,
  input  logic             i_mem_rvalid,
  input  logic [WIDTH-1:0] i_mem_rdata
);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       byteen_q, byteen_d;
  logic             discard_q, discard_d;

  logic if_valid;
  logic if_pick;
  logic d_pick;
  logic starve_inc;
  logic starve_clr;
  logic starve_at_limit;
  logic rsp_fire;

  // A fetch being redirected in the same cycle is not worth starting.
  assign if_valid = i_if_req && !i_if_flush;

  // IDLE arbitration: data first, unless fetch has lost too often in a row.
  always_comb begin
    if_pick = 1'b0;
    d_pick  = 1'b0;
    if (state_q == IDLE) begin
      if (if_valid && (starve_at_limit || !i_d_req)) begin
        if_pick = 1'b1;
      end else if (i_d_req) begin
        d_pick = 1'b1;
      end
    end
  end

  assign starve_inc = d_pick && if_valid;
  assign starve_clr = if_pick;

  mem_arb_starve_counter #(
    .Limit (STARVE_LIMIT)
  ) u_starve_counter (
    .clk_i      (i_clk),
    .rst_ni     (i_reset_n),
    .inc_i      (starve_inc),
    .clr_i      (starve_clr),
    .at_limit_o (starve_at_limit)
  );

  // Next-state logic and request capture.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    byteen_d  = byteen_q;
    discard_d = discard_q;
    unique case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (if_pick) begin
          owner_d  = OWN_IF;
          we_d     = 1'b0;
          addr_d   = i_if_addr;
          wdata_d  = '0;
          byteen_d = BYTEEN_WORD;
          state_d  = REQ;
        end else if (d_pick) begin
          owner_d  = OWN_D;
          we_d     = i_d_we;
          addr_d   = i_d_addr;
          wdata_d  = i_d_wdata;
          byteen_d = i_d_we ? i_d_byteen : BYTEEN_WORD;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (i_mem_gnt) begin
          state_d = WAIT;
          // Accepted by memory already: let it finish, but drop the data.
          if ((owner_q == OWN_IF) && i_if_flush) begin
            discard_d = 1'b1;
          end
        end else if ((owner_q == OWN_IF) && i_if_flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end else if ((owner_q == OWN_IF) && i_if_flush) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      byteen_q  <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      byteen_q  <= byteen_d;
      discard_q <= discard_d;
    end
  end

  assign rsp_fire = (state_q == WAIT) && i_mem_rvalid;

  // Memory port is only driven while a request is being presented; response
  // data passes straight through to the owner. A flush arriving together
  // with the fetch response also cancels it.
  always_comb begin
    o_mem_req    = (state_q == REQ);
    o_mem_we     = o_mem_req && we_q;
    o_mem_addr   = o_mem_req ? addr_q : '0;
    o_mem_wdata  = o_mem_req ? wdata_q : '0;
    o_mem_byteen = o_mem_req ? byteen_q : '0;

    o_if_rvalid  = rsp_fire && (owner_q == OWN_IF) && !discard_q && !i_if_flush;
    o_d_rvalid   = rsp_fire && (owner_q == OWN_D);
    o_if_rdata   = o_if_rvalid ? i_mem_rdata : '0;
    o_d_rdata    = (o_d_rvalid && !we_q) ? i_mem_rdata : '0;

    o_if_stall   = i_if_req && !o_if_rvalid;
    o_d_stall    = i_d_req && !o_d_rvalid;
  end

endmodule

// File: tb/tb_pipelined_mem_arbiter.sv
// Scoreboard bench for pipelined_mem_arbiter: stimulus pushes expected memory
// requests and responses; negedge monitors pop and compare.
module tb_pipelined_mem_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         if_req, if_flush, if_rvalid, if_stall;
  logic [W-1:0] if_addr, if_rdata;
  logic         d_req, d_we, d_rvalid, d_stall;
  logic [W-1:0] d_addr, d_wdata, d_rdata;
  logic [3:0]   d_byteen;
  logic         mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_byteen;

  always #5 clk = ~clk;

  pipelined_mem_arbiter #(
    .WIDTH        (W),
    .STARVE_LIMIT (4)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .i_if_flush   (if_flush),
    .o_if_rdata   (if_rdata),
    .o_if_rvalid  (if_rvalid),
    .o_if_stall   (if_stall),
    .i_d_req      (d_req),
    .i_d_we       (d_we),
    .i_d_addr     (d_addr),
    .i_d_wdata    (d_wdata),
    .i_d_byteen   (d_byteen),
    .o_d_rdata    (d_rdata),
    .o_d_rvalid   (d_rvalid),
    .o_d_stall    (d_stall),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_byteen (mem_byteen),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic [W-1:0] addr;
    logic         we;
    logic [W-1:0] wdata;
    logic [3:0]   byteen;
  } mem_exp_t;

  typedef struct {
    logic         is_d;
    logic [W-1:0] data;
  } rsp_exp_t;

  mem_exp_t     exp_mem_q[$];
  rsp_exp_t     exp_rsp_q[$];
  logic [W-1:0] if_stim_q[$];
  mem_exp_t     d_stim_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string detail);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Memory contents seen by the responder.
  function automatic logic [W-1:0] mem_data(input logic [W-1:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0104: return 32'h0010_0113;
      32'h0000_0108: return 32'hDEAD_BEEF;
      32'h0000_0200: return 32'h0000_0013;
      32'h0000_2000: return 32'h1234_5678;
      default:       return ~a;
    endcase
  endfunction

  // Memory responder: grants when enabled, answers rv_delay cycles after WAIT entry.
  int           rv_delay = 1;
  bit           gnt_en = 1'b1;
  bit           pend = 1'b0;
  int           rv_cnt = 0;
  int           gnt_count = 0;
  logic [W-1:0] pend_data;

  always @(posedge clk) begin
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend) begin
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_data;
        pend       = 1'b0;
      end else begin
        rv_cnt--;
      end
    end else if (mem_req && gnt_en) begin
      mem_gnt   = 1'b1;
      pend      = 1'b1;
      rv_cnt    = rv_delay;
      pend_data = mem_data(mem_addr);
      gnt_count++;
    end
  end

  // Requesters: hold each request until its response, then take the next.
  bit if_rv_seen = 1'b0;
  bit d_rv_seen  = 1'b0;
  bit if_abort   = 1'b0;
  bit d_abort    = 1'b0;

  always @(posedge clk) begin
    mem_exp_t s;
    #1;
    if (if_rv_seen || if_abort) begin
      if_req     = 1'b0;
      if_rv_seen = 1'b0;
      if_abort   = 1'b0;
    end
    if (!if_req && (if_stim_q.size() > 0)) begin
      if_req  = 1'b1;
      if_addr = if_stim_q.pop_front();
    end
    if (d_rv_seen || d_abort) begin
      d_req     = 1'b0;
      d_rv_seen = 1'b0;
      d_abort   = 1'b0;
    end
    if (!d_req && (d_stim_q.size() > 0)) begin
      s        = d_stim_q.pop_front();
      d_req    = 1'b1;
      d_we     = s.we;
      d_addr   = s.addr;
      d_wdata  = s.wdata;
      d_byteen = s.byteen;
    end
  end

  // Monitors: memory-side request order/content and per-owner responses.
  always @(negedge clk) begin
    mem_exp_t e;
    rsp_exp_t r;
    if (mem_req) begin
      if (exp_mem_q.size() == 0) begin
        fail_now("mem_unexpected", $sformatf("got request addr %h, required none", mem_addr));
      end else begin
        e = exp_mem_q[0];
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", W'(mem_we), W'(e.we));
        chk("mem_byteen", W'(mem_byteen), W'(e.byteen));
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        if (mem_gnt) void'(exp_mem_q.pop_front());
      end
    end
    if (if_rvalid) begin
      if ((exp_rsp_q.size() == 0) || exp_rsp_q[0].is_d) begin
        fail_now("if_rvalid_unexpected", $sformatf("got IF data %h, required no IF pulse",
                                                   if_rdata));
      end else begin
        r = exp_rsp_q.pop_front();
        chk("if_rdata", if_rdata, r.data);
      end
      if_rv_seen = 1'b1;
    end
    if (d_rvalid) begin
      if ((exp_rsp_q.size() == 0) || !exp_rsp_q[0].is_d) begin
        fail_now("d_rvalid_unexpected", $sformatf("got D data %h, required no D pulse", d_rdata));
      end else begin
        r = exp_rsp_q.pop_front();
        chk("d_rdata", d_rdata, r.data);
      end
      d_rv_seen = 1'b1;
    end
    chk("if_stall", W'(if_stall), W'(if_req && !if_rvalid));
    chk("d_stall", W'(d_stall), W'(d_req && !d_rvalid));
  end

  task automatic exp_m(input logic [W-1:0] a, input logic we, input logic [W-1:0] wd,
                       input logic [3:0] be);
    exp_mem_q.push_back('{addr: a, we: we, wdata: wd, byteen: be});
  endtask

  task automatic exp_r(input logic is_d, input logic [W-1:0] data);
    exp_rsp_q.push_back('{is_d: is_d, data: data});
  endtask

  task automatic stim_d(input logic we, input logic [W-1:0] a, input logic [W-1:0] wd,
                        input logic [3:0] be);
    d_stim_q.push_back('{addr: a, we: we, wdata: wd, byteen: be});
  endtask

  task automatic wait_done(input string name, input int max);
    bit done = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #3;
      if ((if_stim_q.size() == 0) && (d_stim_q.size() == 0) && !if_req && !d_req && !pend &&
          (exp_mem_q.size() == 0) && (exp_rsp_q.size() == 0)) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      fail_now(name, $sformatf("timeout: %0d mem / %0d rsp still expected",
                               exp_mem_q.size(), exp_rsp_q.size()));
      exp_mem_q.delete();
      exp_rsp_q.delete();
    end
  endtask

  task automatic wait_gnt(input string name, input int max);
    int start = gnt_count;
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #3;
      if (gnt_count != start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now(name, "no grant within cycle budget, required one");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_byteen = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_mem_req", W'(mem_req), '0);
    chk("rst_mem_we", W'(mem_we), '0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_mem_byteen", W'(mem_byteen), '0);
    chk("rst_if_rvalid", W'(if_rvalid), '0);
    chk("rst_d_rvalid", W'(d_rvalid), '0);
    chk("rst_if_rdata", if_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #3;

    // Single fetch.
    rv_delay = 1;
    exp_m(32'h100, 1'b0, '0, 4'hF);
    exp_r(1'b0, 32'h0050_0093);
    if_stim_q.push_back(32'h100);
    wait_done("single_fetch", 40);

    // Simultaneous: data load wins first, then the fetch.
    rv_delay = 0;
    exp_m(32'h2000, 1'b0, '0, 4'hF);
    exp_m(32'h104, 1'b0, '0, 4'hF);
    exp_r(1'b1, 32'h1234_5678);
    exp_r(1'b0, 32'h0010_0113);
    stim_d(1'b0, 32'h2000, 32'hCAFE_0000, 4'b0101);
    if_stim_q.push_back(32'h104);
    wait_done("simultaneous", 40);

    // Starvation: four data grants, then fetch, then data resumes.
    for (int i = 0; i < 4; i++) exp_m(32'h4000 + 32'(4 * i), 1'b0, '0, 4'hF);
    exp_m(32'h300, 1'b0, '0, 4'hF);
    exp_m(32'h4010, 1'b0, '0, 4'hF);
    exp_m(32'h4014, 1'b0, '0, 4'hF);
    exp_r(1'b1, 32'hFFFF_BFFF);
    exp_r(1'b1, 32'hFFFF_BFFB);
    exp_r(1'b1, 32'hFFFF_BFF7);
    exp_r(1'b1, 32'hFFFF_BFF3);
    exp_r(1'b0, 32'hFFFF_FCFF);
    exp_r(1'b1, 32'hFFFF_BFEF);
    exp_r(1'b1, 32'hFFFF_BFEB);
    for (int i = 0; i < 6; i++) stim_d(1'b0, 32'h4000 + 32'(4 * i), '0, 4'hF);
    if_stim_q.push_back(32'h300);
    wait_done("starvation", 100);

    // Flush during WAIT: the late fetch data must not reach the pipeline.
    rv_delay = 3;
    exp_m(32'h108, 1'b0, '0, 4'hF);
    if_stim_q.push_back(32'h108);
    wait_gnt("flush_gnt", 20);
    @(posedge clk);
    #3;
    if_flush = 1'b1;
    if_abort = 1'b1;
    @(posedge clk);
    #3;
    if_flush = 1'b0;
    rv_delay = 1;
    exp_m(32'h200, 1'b0, '0, 4'hF);
    exp_r(1'b0, 32'h0000_0013);
    if_stim_q.push_back(32'h200);
    wait_done("flush_wait", 40);

    // Store held in REQ for several cycles; a flush pulse must not touch it.
    gnt_en = 1'b0;
    exp_m(32'h3000, 1'b1, 32'hA5A5_A5A5, 4'b0011);
    exp_r(1'b1, '0);
    stim_d(1'b1, 32'h3000, 32'hA5A5_A5A5, 4'b0011);
    repeat (2) @(posedge clk);
    #3;
    if_flush = 1'b1;
    @(posedge clk);
    #3;
    if_flush = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    gnt_en = 1'b1;
    wait_done("store", 40);

    // Reset mid-WAIT; the stray response afterwards must be ignored.
    rv_delay = 3;
    exp_m(32'h5000, 1'b0, '0, 4'hF);
    stim_d(1'b0, 32'h5000, '0, 4'hF);
    wait_gnt("reset_gnt", 20);
    @(posedge clk);
    #4;
    rst_n   = 1'b0;
    d_abort = 1'b1;
    #1;
    chk("rstw_mem_req", W'(mem_req), '0);
    chk("rstw_mem_addr", mem_addr, '0);
    chk("rstw_d_rvalid", W'(d_rvalid), '0);
    chk("rstw_if_rvalid", W'(if_rvalid), '0);
    chk("rstw_d_rdata", d_rdata, '0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    chk("stray_pending", W'(pend), '0);

    // Recovery after reset.
    rv_delay = 0;
    exp_m(32'h100, 1'b0, '0, 4'hF);
    exp_r(1'b0, 32'h0050_0093);
    if_stim_q.push_back(32'h100);
    wait_done("post_reset_fetch", 40);

    chk("exp_mem_left", 32'(exp_mem_q.size()), '0);
    chk("exp_rsp_left", 32'(exp_rsp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
